// File: rtl/router_out_arbiter_pkg.sv
// Router-wide types shared by the input FIFOs and the output-port arbiters.
// Flit layout, flit-type encoding and the arbiter FSM state encoding.
package router_out_arbiter_pkg;

    localparam int DEST_W    = 1;
    localparam int DATA_W    = 8;
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        BODY      = 2'b00,
        HEAD      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef struct packed {
        flit_type_e          ftype;
        logic [DEST_W-1:0]   dest;
        logic [DATA_W-1:0]   payload;
    } pkt_flit_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // True for flits that open a packet.
    function automatic logic is_head(input flit_type_e t);
        return (t == HEAD) || (t == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/router_out_arbiter_rr_arb.sv
// Combinational round-robin pick: first set request at or above rr_ptr, with
// wrap-around, so the input at rr_ptr has the highest priority.
module router_rr_arb #(
    parameter int NUM_IN = 2,
    parameter int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [NUM_IN-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              any_gnt
);

    logic [IDX_W-1:0] cand [NUM_IN];

    // cand[k] = (rr_ptr + k) mod NUM_IN, wrapped explicitly so that
    // non-power-of-two input counts never index past the last input.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            logic [IDX_W:0] wrapped;
            assign sum     = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
            assign wrapped = (sum >= (IDX_W+1)'(NUM_IN)) ? (sum - (IDX_W+1)'(NUM_IN)) : sum;
            assign cand[gi] = wrapped[IDX_W-1:0];
        end
    endgenerate

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        // Scan from the lowest priority down so the last hit is the winner.
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                gnt_idx = cand[k];
                any_gnt = 1'b1;
            end
        end
        if (any_gnt) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Output-port arbiter: round-robin packet selection across the input FIFO
// heads, wormhole lock from HEAD to TAIL, registered valid/ready output stage.
module router_out_arbiter
    import router_out_arbiter_pkg::*;
#(
    parameter  int NUM_IN  = 2,
    parameter  int PORT_ID = 0,
    localparam int IDX_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_IN-1:0]      in_empty,
    input  pkt_flit_t [NUM_IN-1:0] in_pkt,
    output logic [NUM_IN-1:0]      in_read,
    output pkt_flit_t              out_pkt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   proto_err
);

    arb_state_e        state_reg, state_next;
    logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]  owner_reg, owner_next;
    pkt_flit_t         out_pkt_reg;
    logic              out_valid_reg;
    logic              proto_err_reg, proto_err_next;

    logic [NUM_IN-1:0] req, drop_req;
    logic [NUM_IN-1:0] fwd_gnt, drop_gnt;
    logic [IDX_W-1:0]  fwd_idx, drop_idx;
    logic              fwd_any, drop_any;

    logic              load_ok;
    logic              load;
    pkt_flit_t         load_pkt;
    logic [NUM_IN-1:0] pop;
    pkt_flit_t         owner_flit;

    function automatic logic [IDX_W-1:0] rr_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_IN - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // Only flits addressed to this port are considered; heads request a grant,
    // orphaned BODY/TAIL flits request a drop.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_req
            logic for_us;
            assign for_us       = !in_empty[gi] && (in_pkt[gi].dest == DEST_W'(PORT_ID));
            assign req[gi]      = for_us && is_head(in_pkt[gi].ftype);
            assign drop_req[gi] = for_us && !is_head(in_pkt[gi].ftype);
        end
    endgenerate

    router_rr_arb #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) u_fwd_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_reg),
        .gnt     (fwd_gnt),
        .gnt_idx (fwd_idx),
        .any_gnt (fwd_any)
    );

    router_rr_arb #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) u_drop_arb (
        .req     (drop_req),
        .rr_ptr  (rr_ptr_reg),
        .gnt     (drop_gnt),
        .gnt_idx (drop_idx),
        .any_gnt (drop_any)
    );

    assign load_ok    = !out_valid_reg || out_ready;
    assign owner_flit = in_pkt[owner_reg];

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        owner_next     = owner_reg;
        proto_err_next = 1'b0;
        pop            = '0;
        load           = 1'b0;
        load_pkt       = owner_flit;
        case (state_reg)
            IDLE: begin
                if (load_ok) begin
                    if (fwd_any) begin
                        pop        = fwd_gnt;
                        load       = 1'b1;
                        load_pkt   = in_pkt[fwd_idx];
                        owner_next = fwd_idx;
                        if (in_pkt[fwd_idx].ftype == HEAD) begin
                            state_next = LOCKED;
                        end else begin
                            rr_ptr_next = rr_inc(fwd_idx);
                        end
                    end else if (drop_any) begin
                        // Orphaned flit: discard it so it cannot block the FIFO.
                        pop            = drop_gnt;
                        proto_err_next = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (!in_empty[owner_reg]) begin
                    if (is_head(owner_flit.ftype)) begin
                        // Truncated packet: release the lock and leave the new
                        // head in place so it competes as a fresh packet.
                        proto_err_next = 1'b1;
                        state_next     = IDLE;
                        rr_ptr_next    = rr_inc(owner_reg);
                    end else if (load_ok) begin
                        pop[owner_reg] = 1'b1;
                        load           = 1'b1;
                        load_pkt       = owner_flit;
                        if (owner_flit.ftype == TAIL) begin
                            state_next  = IDLE;
                            rr_ptr_next = rr_inc(owner_reg);
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            out_pkt_reg   <= '0;
            out_valid_reg <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            owner_reg     <= owner_next;
            proto_err_reg <= proto_err_next;
            if (load) begin
                out_pkt_reg   <= load_pkt;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign in_read   = rst ? '0 : pop;
    assign out_pkt   = out_pkt_reg;
    assign out_valid = out_valid_reg;
    assign grant_id  = owner_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Self-checking bench: FIFO models feed the arbiter, a scoreboard queue holds
// the flits expected on the link in order.
`timescale 1ns/1ps
module tb_router_out_arbiter;
    import router_out_arbiter_pkg::*;

    localparam int NUM_IN = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [NUM_IN-1:0]      in_empty;
    pkt_flit_t [NUM_IN-1:0] in_pkt;
    logic [NUM_IN-1:0]      in_read;
    pkt_flit_t              out_pkt;
    logic                   out_valid;
    logic                   out_ready;
    logic [0:0]             grant_id;
    logic                   proto_err;

    always #5 clk = ~clk;

    router_out_arbiter #(.NUM_IN(NUM_IN), .PORT_ID(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_empty  (in_empty),
        .in_pkt    (in_pkt),
        .in_read   (in_read),
        .out_pkt   (out_pkt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .proto_err (proto_err)
    );

    pkt_flit_t   fifo0[$];
    pkt_flit_t   fifo1[$];
    pkt_flit_t   exp_q[$];
    logic [0:0]  gnt_log[$];
    int          checks = 0;
    int          errors = 0;
    int          err_pulses = 0;
    int          cyc = 0;

    logic [NUM_IN-1:0] s_rd, s_empty;
    logic              s_ov, s_ordy, s_perr;
    pkt_flit_t         s_op;
    logic [0:0]        s_gnt;

    function automatic pkt_flit_t mk(input flit_type_e t, input logic d, input logic [7:0] p);
        pkt_flit_t f;
        f.ftype   = t;
        f.dest    = d;
        f.payload = p;
        return f;
    endfunction

    task automatic refresh();
        in_empty[0] = (fifo0.size() == 0);
        in_empty[1] = (fifo1.size() == 0);
        if (fifo0.size() > 0) in_pkt[0] = fifo0[0]; else in_pkt[0] = '0;
        if (fifo1.size() > 0) in_pkt[1] = fifo1[0]; else in_pkt[1] = '0;
    endtask

    task automatic push(input int i, input pkt_flit_t f, input bit fwd);
        if (i == 0) fifo0.push_back(f); else fifo1.push_back(f);
        if (fwd) exp_q.push_back(f);
        refresh();
    endtask

    // One clock: sample at the falling edge, apply pops after the rising edge.
    task automatic tick();
        pkt_flit_t e;
        @(negedge clk);
        s_rd = in_read; s_empty = in_empty; s_ov = out_valid; s_ordy = out_ready;
        s_op = out_pkt; s_perr = proto_err; s_gnt = grant_id;
        checks++;
        if ($countones(s_rd) > 1 || (s_rd & s_empty) != '0 || (s_rd != '0 && s_ov && !s_ordy)) begin
            errors++;
            $display("FAIL pop_legal cyc=%0d in_read=%b in_empty=%b out_valid=%b out_ready=%b",
                     cyc, s_rd, s_empty, s_ov, s_ordy);
        end
        if (s_perr) err_pulses++;
        if (s_ov && s_ordy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d got %h expected no flit", cyc, s_op);
            end else begin
                e = exp_q.pop_front();
                if (s_op !== e) begin
                    errors++;
                    $display("FAIL scoreboard cyc=%0d got %h expected %h", cyc, s_op, e);
                end else begin
                    $display("cyc=%0d flit %h accepted grant_id=%0d", cyc, s_op, s_gnt);
                end
                if (is_head(s_op.ftype)) gnt_log.push_back(s_gnt);
            end
        end
        @(posedge clk);
        #1;
        if (s_rd[0] && fifo0.size() > 0) fifo0.delete(0);
        if (s_rd[1] && fifo1.size() > 0) fifo1.delete(0);
        cyc++;
        refresh();
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL %s_drain pending=%0d out_valid=%b required pending=0 out_valid=0",
                     name, exp_q.size(), out_valid);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo0.delete(); fifo1.delete(); exp_q.delete(); gnt_log.delete();
        refresh();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        refresh();
        #2 rst = 1'b1;
        tick(); tick();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b need 0", out_valid); end
        if (out_pkt !== '0) begin errors++; $display("FAIL rst_out_pkt got %h need 0", out_pkt); end
        if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err got %b need 0", proto_err); end
        if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant_id got %b need 0", grant_id); end
        if (in_read !== 2'b00) begin errors++; $display("FAIL rst_in_read got %b need 00", in_read); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        out_ready = 1'b1;
        push(0, mk(HEAD, 1'b0, 8'h81), 1'b1);
        push(0, mk(BODY, 1'b0, 8'h82), 1'b1);
        push(0, mk(BODY, 1'b0, 8'h83), 1'b1);
        tick(); tick();
        rst = 1'b1;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b need 0", out_valid); end
        if (in_read !== 2'b00) begin errors++; $display("FAIL midrst_in_read got %b need 00", in_read); end
        fifo0.delete(); fifo1.delete(); exp_q.delete(); gnt_log.delete();
        refresh();
        tick();
        rst = 1'b0;
        push(1, mk(HEAD_TAIL, 1'b0, 8'h5a), 1'b1);
        drain("midrst");
        checks++;
        if (grant_id !== 1'b1) begin errors++; $display("FAIL midrst_grant got %b need 1", grant_id); end
    endtask

    task automatic test_single();
        logic [1:0] exp_rd;
        logic       exp_ov;
        do_reset();
        out_ready = 1'b1;
        push(0, mk(HEAD, 1'b0, 8'h11), 1'b1);
        push(0, mk(BODY, 1'b0, 8'h22), 1'b1);
        push(0, mk(TAIL, 1'b0, 8'h33), 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_rd = (k < 3) ? 2'b01 : 2'b00;
            exp_ov = (k >= 1);
            checks++;
            if (s_rd !== exp_rd || s_ov !== exp_ov) begin
                errors++;
                $display("FAIL single_timing k=%0d in_read=%b out_valid=%b need %b %b",
                         k, s_rd, s_ov, exp_rd, exp_ov);
            end
        end
        drain("single");
        // rr_ptr is now 1: input 1 must win a simultaneous request.
        push(1, mk(HEAD_TAIL, 1'b0, 8'h44), 1'b1);
        push(0, mk(HEAD_TAIL, 1'b0, 8'h55), 1'b1);
        drain("single_rr");
    endtask

    task automatic test_contention();
        do_reset();
        out_ready = 1'b1;
        push(0, mk(HEAD, 1'b0, 8'ha1), 1'b1);
        push(0, mk(BODY, 1'b0, 8'ha2), 1'b1);
        push(0, mk(TAIL, 1'b0, 8'ha3), 1'b1);
        push(1, mk(HEAD, 1'b0, 8'hb1), 1'b1);
        push(1, mk(TAIL, 1'b0, 8'hb2), 1'b1);
        drain("contention");
        checks++;
        if (gnt_log.size() != 2 || gnt_log[0] !== 1'b0 || gnt_log[1] !== 1'b1) begin
            errors++;
            $display("FAIL contention_grants got n=%0d need grants 0 then 1", gnt_log.size());
        end
    endtask

    task automatic test_backpressure();
        pkt_flit_t held;
        out_ready = 1'b1;
        push(0, mk(HEAD, 1'b0, 8'hc1), 1'b1);
        push(0, mk(BODY, 1'b0, 8'hc2), 1'b1);
        push(0, mk(BODY, 1'b0, 8'hc3), 1'b1);
        push(0, mk(TAIL, 1'b0, 8'hc4), 1'b1);
        tick(); tick();
        out_ready = 1'b0;
        held = out_pkt;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (s_ov !== 1'b1 || s_op !== held || s_rd !== 2'b00) begin
                errors++;
                $display("FAIL backpressure_hold k=%0d out_valid=%b out_pkt=%h in_read=%b need 1 %h 00",
                         k, s_ov, s_op, s_rd, held);
            end
        end
        out_ready = 1'b1;
        drain("backpressure");
    endtask

    task automatic test_owner_stall();
        out_ready = 1'b1;
        push(0, mk(HEAD, 1'b0, 8'hd1), 1'b1);
        push(0, mk(BODY, 1'b0, 8'hd2), 1'b1);
        tick(); tick();
        push(1, mk(HEAD, 1'b0, 8'he1), 1'b0);
        push(1, mk(TAIL, 1'b0, 8'he2), 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (s_rd !== 2'b00) begin
                errors++;
                $display("FAIL owner_stall k=%0d in_read=%b need 00", k, s_rd);
            end
        end
        push(0, mk(TAIL, 1'b0, 8'hd3), 1'b1);
        exp_q.push_back(mk(HEAD, 1'b0, 8'he1));
        exp_q.push_back(mk(TAIL, 1'b0, 8'he2));
        drain("owner_stall");
    endtask

    task automatic test_proto_body();
        int e0;
        out_ready = 1'b1;
        e0 = err_pulses;
        push(0, mk(HEAD, 1'b1, 8'h66), 1'b0);
        push(1, mk(BODY, 1'b0, 8'h77), 1'b0);
        tick(); tick(); tick();
        checks += 3;
        if (err_pulses - e0 != 1) begin errors++; $display("FAIL body_drop_err got %0d pulses need 1", err_pulses - e0); end
        if (fifo1.size() != 0) begin errors++; $display("FAIL body_drop_pop got depth %0d need 0", fifo1.size()); end
        if (fifo0.size() != 1) begin errors++; $display("FAIL other_port_kept got depth %0d need 1", fifo0.size()); end
        do_reset();
        // A valid head outranks an orphan in the same cycle.
        out_ready = 1'b1;
        e0 = err_pulses;
        push(0, mk(BODY, 1'b0, 8'h67), 1'b0);
        push(1, mk(HEAD_TAIL, 1'b0, 8'h68), 1'b1);
        tick();
        checks++;
        if (s_rd !== 2'b10) begin errors++; $display("FAIL req_over_drop in_read=%b need 10", s_rd); end
        drain("req_over_drop");
        tick();
        checks++;
        if (err_pulses - e0 != 1 || fifo0.size() != 0) begin
            errors++;
            $display("FAIL req_over_drop_err pulses=%0d depth=%0d need 1 0", err_pulses - e0, fifo0.size());
        end
    endtask

    task automatic test_proto_head_locked();
        int e0;
        out_ready = 1'b1;
        e0 = err_pulses;
        push(0, mk(HEAD, 1'b0, 8'hf1), 1'b1);
        push(0, mk(BODY, 1'b0, 8'hf2), 1'b1);
        tick(); tick();
        push(0, mk(HEAD, 1'b0, 8'h91), 1'b1);
        push(0, mk(TAIL, 1'b0, 8'h92), 1'b1);
        tick();
        checks++;
        if (s_rd !== 2'b00) begin errors++; $display("FAIL locked_head_nopop in_read=%b need 00", s_rd); end
        drain("locked_head");
        checks += 2;
        if (err_pulses - e0 != 1) begin errors++; $display("FAIL locked_head_err got %0d pulses need 1", err_pulses - e0); end
        if (fifo0.size() != 0) begin errors++; $display("FAIL locked_head_regrant depth %0d need 0", fifo0.size()); end
    endtask

    initial begin
        out_ready = 1'b1;
        refresh();
        test_reset();
        test_reset_mid_packet();
        test_single();
        test_contention();
        test_backpressure();
        test_owner_stall();
        test_proto_body();
        test_proto_head_locked();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
